test_mem_resp_rand_delay: RTL and testbench

- Single-entry, order-preserving response stage placed directly downstream of the test memory's response queue (one instance per imem/dmem response port).
- Holds each response message for a pseudo-random number of cycles before presenting it to the consumer, so processor and cache testbenches exercise response-side stalls.
- Deterministic for a given seed; message contents pass through bit-exact.

---
 rtl/test_mem_resp_rand_delay.sv | 116 +++++++++++
 tb/tb_test_mem_resp_rand_delay.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_mem_resp_rand_delay.sv
// Single-entry response stage that holds each message for an LFSR-chosen delay before presenting it.
// Optional counters enabled by TEST_MEM_RESP_RAND_DELAY_STATS_EN (num_msgs, num_stall_cycles).
module test_mem_resp_rand_delay #(
    parameter int unsigned p_data_nbits = 32,
    parameter int unsigned p_max_delay  = 4,
    parameter logic [31:0] p_seed       = 32'hb9b9_b9b9,
    localparam int unsigned MSG_NBITS   = p_data_nbits + $clog2(p_data_nbits / 8) + 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [MSG_NBITS-1:0] in_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [MSG_NBITS-1:0] out_msg
`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
    ,
    output logic [31:0]          num_msgs,
    output logic [31:0]          num_stall_cycles
`endif
);

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [16:0] DIVISOR   = 17'(p_max_delay + 1);

    typedef enum logic [1:0] {StIdle, StDelay, StSend} state_e;

    state_e               r_state, w_state_next;
    logic [7:0]           r_cnt, w_cnt_next;
    logic [31:0]          r_lfsr, w_lfsr_next;
    logic [MSG_NBITS-1:0] r_buf;
    logic                 w_accept;
    logic [7:0]           w_delay;

    // Delay is drawn from the LFSR value before it advances on this accept.
    always_comb begin
        w_delay = 8'({1'b0, r_lfsr[15:0]} % DIVISOR);
    end

    always_comb begin
        in_rdy   = reset & ((r_state == StIdle) | ((r_state == StSend) & out_rdy));
        w_accept = in_val & in_rdy;
        out_val  = (r_state == StSend);
        out_msg  = r_buf;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lfsr_next  = r_lfsr;
        unique case (r_state)
            StIdle: ;
            StDelay: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_state_next = StSend;
                    w_cnt_next   = 8'd0;
                end
            end
            StSend: begin
                if (out_rdy) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
        // An accept in SEND overrides the dequeue-to-IDLE transition (zero-bubble handoff).
        if (w_accept) begin
            w_cnt_next   = w_delay;
            w_lfsr_next  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
            w_state_next = (w_delay == 8'd0) ? StSend : StDelay;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_lfsr  <= p_seed;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_lfsr  <= w_lfsr_next;
            if (w_accept) begin
                r_buf <= in_msg;
            end
        end
    end

`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
    logic [31:0] r_num_msgs;
    logic [31:0] r_num_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_num_msgs  <= 32'd0;
            r_num_stall <= 32'd0;
        end else begin
            if (out_val & out_rdy) begin
                r_num_msgs <= r_num_msgs + 32'd1;
            end
            if ((r_state == StDelay) | ((r_state == StSend) & ~out_rdy)) begin
                r_num_stall <= r_num_stall + 32'd1;
            end
        end
    end

    always_comb begin
        num_msgs         = r_num_msgs;
        num_stall_cycles = r_num_stall;
    end
`endif

endmodule

// File: tb/tb_test_mem_resp_rand_delay.sv
// Bench for test_mem_resp_rand_delay: one instance with max delay 4, one with delay insertion off.
// Stats ports are checked when TEST_MEM_RESP_RAND_DELAY_STATS_EN is defined.
module tb_test_mem_resp_rand_delay;

    localparam int MW = 48;
    localparam int MAXD = 4;
    localparam logic [31:0] SEED = 32'hb9b9_b9b9;

    logic          clk, reset;
    logic          in_val, in_rdy, out_val, out_rdy;
    logic [MW-1:0] in_msg, out_msg;
    logic          z_in_val, z_in_rdy, z_out_val, z_out_rdy;
    logic [MW-1:0] z_in_msg, z_out_msg;
`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
    logic [31:0]   num_msgs, num_stall, z_num_msgs, z_num_stall;
`endif

    int            total, bad;
    logic [31:0]   m_lfsr;

    test_mem_resp_rand_delay #(.p_data_nbits(32), .p_max_delay(MAXD), .p_seed(SEED)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg)
`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
        , .num_msgs(num_msgs), .num_stall_cycles(num_stall)
`endif
    );

    test_mem_resp_rand_delay #(.p_data_nbits(32), .p_max_delay(0), .p_seed(SEED)) dut_z (
        .clk(clk), .reset(reset), .in_val(z_in_val), .in_rdy(z_in_rdy), .in_msg(z_in_msg),
        .out_val(z_out_val), .out_rdy(z_out_rdy), .out_msg(z_out_msg)
`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
        , .num_msgs(z_num_msgs), .num_stall_cycles(z_num_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: delay for the next message, then advance the Galois LFSR one step.
    task automatic take_d(output int d);
        d = int'(m_lfsr[15:0]) % (MAXD + 1);
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
    endtask

    function automatic logic [MW-1:0] rand_msg();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0; z_in_val = 1'b0; z_out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_lfsr = SEED;
    endtask

    task automatic send_one(input logic [MW-1:0] msg, input string name);
        int d, k;
        @(negedge clk);
        in_val = 1'b1; in_msg = msg; out_rdy = 1'b1;
        #1;
        total++;
        if (in_rdy !== 1'b1) begin
            bad++; $display("FAIL %s accept: in_rdy=%b want 1", name, in_rdy);
        end
        take_d(d);
        @(negedge clk);
        in_val = 1'b0; in_msg = rand_msg();
        #1;
        k = 0;
        while (out_val !== 1'b1 && k < 300) begin
            @(negedge clk); #1; k++;
        end
        total++;
        if (out_val !== 1'b1) begin
            bad++; $display("FAIL %s timeout: out_val=%b want 1", name, out_val);
        end else begin
            if (k != d) begin
                bad++; $display("FAIL %s latency: got %0d want %0d", name, k + 1, d + 1);
            end
            total++;
            if (out_msg !== msg) begin
                bad++; $display("FAIL %s msg: got %h want %h", name, out_msg, msg);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0; in_val = 1'b1; out_rdy = 1'b1; z_in_val = 1'b1; z_out_rdy = 1'b1;
        in_msg = rand_msg(); z_in_msg = rand_msg();
        @(negedge clk); #1;
        total += 5;
        if (in_rdy !== 1'b0) begin bad++; $display("FAIL rst in_rdy: got %b want 0", in_rdy); end
        if (out_val !== 1'b0) begin bad++; $display("FAIL rst out_val: got %b want 0", out_val); end
        if (out_msg !== '0) begin bad++; $display("FAIL rst out_msg: got %h want 0", out_msg); end
        if (z_in_rdy !== 1'b0) begin bad++; $display("FAIL rst z_in_rdy: got %b want 0", z_in_rdy); end
        if (z_out_val !== 1'b0) begin bad++; $display("FAIL rst z_out_val: got %b want 0", z_out_val); end
`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
        total += 2;
        if (num_msgs !== 32'd0) begin bad++; $display("FAIL rst num_msgs: got %0d want 0", num_msgs); end
        if (num_stall !== 32'd0) begin bad++; $display("FAIL rst stall: got %0d want 0", num_stall); end
`endif
    endtask

    task automatic test_zero_delay;
        @(negedge clk);
        z_out_rdy = 1'b1; z_in_val = 1'b1; z_in_msg = 48'd1;
        #1;
        total += 2;
        if (z_in_rdy !== 1'b1) begin bad++; $display("FAIL z0 in_rdy: got %b want 1", z_in_rdy); end
        if (z_out_val !== 1'b0) begin bad++; $display("FAIL z0 out_val: got %b want 0", z_out_val); end
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) z_in_val = 1'b0;
            else z_in_msg = 48'(i);
            #1;
            total += 3;
            if (i < 4 && z_in_rdy !== 1'b1) begin
                bad++; $display("FAIL z%0d in_rdy: got %b want 1", i, z_in_rdy);
            end
            if (z_out_val !== 1'b1) begin
                bad++; $display("FAIL z%0d out_val: got %b want 1", i, z_out_val);
            end
            if (z_out_msg !== 48'(i - 1)) begin
                bad++; $display("FAIL z%0d out_msg: got %h want %h", i, z_out_msg, 48'(i - 1));
            end
        end
        @(negedge clk); #1;
        total++;
        if (z_out_val !== 1'b0) begin bad++; $display("FAIL z_end out_val: got %b want 0", z_out_val); end
`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
        total += 2;
        if (z_num_msgs !== 32'd3) begin bad++; $display("FAIL z num_msgs: got %0d want 3", z_num_msgs); end
        if (z_num_stall !== 32'd0) begin bad++; $display("FAIL z stall: got %0d want 0", z_num_stall); end
`endif
    endtask

    task automatic test_latency;
        do_reset();
        for (int i = 0; i < 8; i++) send_one(rand_msg(), $sformatf("lat%0d", i));
    endtask

    task automatic test_stall;
        logic [MW-1:0] a, b;
        int da, db, k;
        a = rand_msg(); b = rand_msg();
        @(negedge clk);
        in_val = 1'b1; in_msg = a; out_rdy = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b1) begin bad++; $display("FAIL stall accept: in_rdy=%b want 1", in_rdy); end
        take_d(da);
        @(negedge clk);
        in_msg = b;
        #1;
        k = 0;
        while (out_val !== 1'b1 && k < 300) begin
            @(negedge clk); #1; k++;
        end
        total++;
        if (k != da) begin bad++; $display("FAIL stall latency: got %0d want %0d", k + 1, da + 1); end
        for (int i = 0; i < 5; i++) begin
            total += 3;
            if (out_val !== 1'b1) begin bad++; $display("FAIL stall%0d out_val: got %b want 1", i, out_val); end
            if (out_msg !== a) begin bad++; $display("FAIL stall%0d msg: got %h want %h", i, out_msg, a); end
            if (in_rdy !== 1'b0) begin bad++; $display("FAIL stall%0d in_rdy: got %b want 0", i, in_rdy); end
            @(negedge clk); #1;
        end
        out_rdy = 1'b1;
        #1;
        total += 2;
        if (in_rdy !== 1'b1) begin bad++; $display("FAIL handoff in_rdy: got %b want 1", in_rdy); end
        if (out_val !== 1'b1 || out_msg !== a) begin
            bad++; $display("FAIL handoff out: got %b/%h want 1/%h", out_val, out_msg, a);
        end
        take_d(db);
        @(negedge clk);
        in_val = 1'b0;
        #1;
        k = 0;
        while (out_val !== 1'b1 && k < 300) begin
            @(negedge clk); #1; k++;
        end
        total += 2;
        if (k != db) begin bad++; $display("FAIL handoff latency: got %0d want %0d", k + 1, db + 1); end
        if (out_msg !== b) begin bad++; $display("FAIL handoff msg: got %h want %h", out_msg, b); end
    endtask

    task automatic test_passthrough;
        logic [MW-1:0] m;
        m = {4'h0, 8'h5a, 2'b00, 2'b00, 32'hdead_beef};
        send_one(m, "passthru");
    endtask

    // Transaction-level model: one pending message, released d+1 cycles after its accept.
    task automatic test_random_stream;
        bit has, ev, er;
        logic [MW-1:0] hm;
        int trel, d;
        has = 1'b0; trel = 0; hm = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            in_val = 1'($urandom % 2); out_rdy = (($urandom % 4) != 0); in_msg = rand_msg();
            #1;
            ev = has && (c >= trel);
            er = !has || (ev && out_rdy);
            total += 2;
            if (in_rdy !== er) begin bad++; $display("FAIL rnd%0d in_rdy: got %b want %b", c, in_rdy, er); end
            if (out_val !== ev) begin bad++; $display("FAIL rnd%0d out_val: got %b want %b", c, out_val, ev); end
            if (ev) begin
                total++;
                if (out_msg !== hm) begin bad++; $display("FAIL rnd%0d msg: got %h want %h", c, out_msg, hm); end
            end
            if (ev && out_rdy) has = 1'b0;
            if (in_val && er) begin
                take_d(d);
                has = 1'b1; hm = in_msg; trel = c + 1 + d;
            end
        end
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic test_reset_mid;
        int d, n;
        do_reset();
        n = 0;
        while ((int'(m_lfsr[15:0]) % (MAXD + 1)) < 3 && n < 40) begin
            send_one(rand_msg(), "pre_mid");
            n++;
        end
        @(negedge clk);
        in_val = 1'b1; in_msg = rand_msg(); out_rdy = 1'b1;
        take_d(d);
        @(negedge clk);
        in_val = 1'b0;
        total++;
        if (d < 3) begin bad++; $display("FAIL mid setup: d=%0d want >=3", d); end
        if (d > 3) repeat (d - 3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        total += 2;
        if (out_val !== 1'b0) begin bad++; $display("FAIL mid out_val: got %b want 0", out_val); end
        if (in_rdy !== 1'b0) begin bad++; $display("FAIL mid in_rdy: got %b want 0", in_rdy); end
        reset = 1'b1;
        m_lfsr = SEED;
        send_one(rand_msg(), "post_mid");
    endtask

`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
    task automatic test_stats;
        int sum_d;
        logic [31:0] s;
        do_reset();
        sum_d = 0;
        s = m_lfsr;
        for (int i = 0; i < 4; i++) begin
            sum_d += int'(s[15:0]) % (MAXD + 1);
            s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
        for (int i = 0; i < 4; i++) send_one(rand_msg(), $sformatf("stat%0d", i));
        @(negedge clk); #1;
        total += 2;
        if (num_msgs !== 32'd4) begin bad++; $display("FAIL stats num_msgs: got %0d want 4", num_msgs); end
        if (num_stall !== 32'(sum_d)) begin
            bad++; $display("FAIL stats stall: got %0d want %0d", num_stall, sum_d);
        end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0; in_msg = '0;
        z_in_val = 1'b0; z_out_rdy = 1'b0; z_in_msg = '0;
        m_lfsr = SEED;
        test_reset();
        do_reset();
        test_zero_delay();
        test_latency();
        test_stall();
        test_passthrough();
        test_random_stream();
        test_reset_mid();
`ifdef TEST_MEM_RESP_RAND_DELAY_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
